// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer: opcodes, FSM states
// and table-entry field layout {op, dev, reg, data}.
package i2c_cfg_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned DEV_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE  = 2'd0,
    OP_VERIFY = 2'd1,
    OP_DELAY  = 2'd2,
    OP_END    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DELAY,
    ST_DONE,
    ST_FAIL
  } state_e;

  function automatic int unsigned entry_w(int unsigned ra_w, int unsigned d_w);
    return OP_W + DEV_W + ra_w + d_w;
  endfunction

  function automatic int unsigned op_lsb(int unsigned ra_w, int unsigned d_w);
    return DEV_W + ra_w + d_w;
  endfunction

  function automatic int unsigned dev_lsb(int unsigned ra_w, int unsigned d_w);
    return ra_w + d_w;
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Down-counter for DELAY entries: load a count, decrement on request, flag zero.
module cfg_delay_cnt #(
  parameter int unsigned CW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Zero flag tracks the next count so it is valid the cycle after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks an external register table and drives an I2C master request channel,
// with per-entry retries, read-back verification and programmable delays.
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned TBL_AW    = 9,
  parameter int unsigned RA_W      = 8,
  parameter int unsigned D_W       = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned DLY_SHIFT = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TBL_AW-1:0]         tbl_size,
  output logic [TBL_AW-1:0]         tbl_index,
  input  logic [2+8+RA_W+D_W-1:0]   tbl_entry,
  output logic                      i2c_req,
  input  logic                      i2c_ack,
  output logic                      i2c_rd,
  output logic [7:0]                i2c_dev,
  output logic [RA_W-1:0]           i2c_reg,
  output logic [D_W-1:0]            i2c_wdata,
  input  logic                      i2c_done,
  input  logic                      i2c_nack,
  input  logic [D_W-1:0]            i2c_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [TBL_AW-1:0]         fail_index,
  output logic [7:0]                err_cnt
);

  localparam int unsigned OP_LSB  = op_lsb(RA_W, D_W);
  localparam int unsigned DEV_LSB = dev_lsb(RA_W, D_W);
  localparam int unsigned CNT_W   = D_W + DLY_SHIFT;
  localparam int unsigned RTY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d, f_op;
  logic [TBL_AW-1:0]   idx_q, idx_d, size_q, size_d, fidx_q, fidx_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic [RA_W-1:0]     reg_q, reg_d;
  logic [D_W-1:0]      data_q, data_d, rdata_q, rdata_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [7:0]          err_q, err_d;
  logic                done_q, done_d, fail_q, fail_d;
  logic                req_q, req_d, rd_q, rd_d, busy_q, busy_d;
  logic                pass_c, retry_c;
  logic                dly_load, dly_dec, dly_zero;
  logic [CNT_W-1:0]    f_dly, dly_val;

  assign f_op  = op_e'(tbl_entry[OP_LSB +: OP_W]);
  assign f_dly = CNT_W'(tbl_entry[D_W-1:0]) << DLY_SHIFT;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    size_d   = size_q;
    fidx_d   = fidx_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    retry_d  = retry_q;
    err_d    = err_q;
    done_d   = done_q;
    fail_d   = fail_q;
    pass_c   = 1'b0;
    retry_c  = 1'b0;
    dly_load = 1'b0;
    dly_dec  = 1'b0;
    // DELAY state occupies exactly N cycles, so preload N-1 (minimum one cycle).
    dly_val  = (f_dly == '0) ? '0 : f_dly - CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          size_d  = tbl_size;
          fidx_d  = '0;
          retry_d = '0;
          err_d   = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        op_d   = f_op;
        dev_d  = tbl_entry[DEV_LSB +: DEV_W];
        reg_d  = tbl_entry[D_W +: RA_W];
        data_d = tbl_entry[D_W-1:0];
        if ((idx_q >= size_q) || (f_op == OP_END)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (f_op == OP_DELAY) begin
          state_d  = ST_DELAY;
          dly_load = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i2c_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i2c_done) begin
          if (i2c_nack) begin
            retry_c = 1'b1;
          end else begin
            rdata_d = i2c_rdata;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if ((op_q == OP_VERIFY) && (rdata_q != data_q)) retry_c = 1'b1;
        else                                            pass_c  = 1'b1;
      end
      ST_DELAY: begin
        if (dly_zero) pass_c  = 1'b1;
        else          dly_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pass_c) begin
      idx_d   = idx_q + TBL_AW'(1);
      retry_d = '0;
      state_d = ST_FETCH;
    end

    if (retry_c) begin
      err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RTY_W'(1);
        state_d = ST_ISSUE;
      end else begin
        state_d = ST_FAIL;
        fail_d  = 1'b1;
        fidx_d  = idx_q;
      end
    end

    req_d  = (state_d == ST_ISSUE);
    rd_d   = (op_d == OP_VERIFY);
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WRITE;
      idx_q   <= '0;
      size_q  <= '0;
      fidx_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      retry_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      req_q   <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      fidx_q  <= fidx_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  cfg_delay_cnt #(
    .CW(CNT_W)
  ) u_dly (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

  assign tbl_index  = idx_q;
  assign i2c_req    = req_q;
  assign i2c_rd     = rd_q;
  assign i2c_dev    = dev_q;
  assign i2c_reg    = reg_q;
  assign i2c_wdata  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_index = fidx_q;
  assign err_cnt    = err_q;

endmodule
